// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants: reset PC default, nop/bubble encodings, IF FSM states.
// No logic; constants and a pure helper only.
// Not applicable (no flow control in a package).
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_IR           = 32'h0000_0000;
  localparam logic [31:0] BUBBLE_SIG       = 32'h8000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // IF fetch FSM encoding
  localparam logic [1:0] ST_FETCH  = 2'd0;  // request outstanding at pc
  localparam logic [1:0] ST_HOLD   = 2'd1;  // word parked in skid buffer, ID stalled
  localparam logic [1:0] ST_DRAIN  = 2'd2;  // old request still open after a redirect
  localparam logic [1:0] ST_HALTED = 2'd3;  // program exited, only reset leaves

  // Fetch addresses are always word aligned; low bits of any redirect are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_buf.sv
// One-entry skid buffer holding (pc+4, instruction) for a word accepted while ID is stalled.
// Latency: written data visible on o_* the cycle after i_wr.
// Backpressure: owner must not write while o_vld is set; i_clr wins over i_wr.
module if_id_buf
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_wr,
  input  logic        i_clr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_ir,
  output logic        o_vld,
  output logic [31:0] o_pc,
  output logic [31:0] o_ir
);

  logic        r_vld;
  logic [31:0] r_pc;
  logic [31:0] r_ir;

  // Capture a parked word, or drop it on consume/flush/halt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
      r_pc  <= '0;
      r_ir  <= NOP_IR;
    end else if (i_clr) begin
      r_vld <= 1'b0;
    end else if (i_wr) begin
      r_vld <= 1'b1;
      r_pc  <= i_pc;
      r_ir  <= i_ir;
    end
  end

  assign o_vld = r_vld;
  assign o_pc  = r_pc;
  assign o_ir  = r_ir;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: drives imem requests, loads IF/ID with instructions or bubbles.
// Latency: an accepted word appears on out_ir one cycle after its accepting edge (if not stalled).
// Backpressure: stall parks one accepted word in a skid buffer and stops requesting until released.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] out_pc,
  output logic [31:0] out_ir,
  output logic [31:0] out_signal,
  output logic [31:0] fetch_count
);

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_drain_addr;
  logic [31:0] r_out_pc;
  logic [31:0] r_out_ir;
  logic [31:0] r_out_sig;
  logic [31:0] r_fetch_count;

  logic        w_req;
  logic        w_accept;
  logic [31:0] w_pc_inc;

  logic [1:0]  w_nxt_state;
  logic [31:0] w_nxt_pc;
  logic [31:0] w_nxt_drain;
  logic        w_ifid_ld;
  logic        w_ifid_bubble;
  logic [31:0] w_ifid_pc;
  logic [31:0] w_ifid_ir;
  logic        w_cnt_inc;
  logic        w_buf_wr;
  logic        w_buf_clr;
  logic        w_buf_vld;
  logic [31:0] w_buf_pc;
  logic [31:0] w_buf_ir;

  // Request is live in FETCH and DRAIN; forced low while reset is asserted so a
  // mid-request reset abandons the access in the same cycle.
  assign w_req    = rst_n && ((r_state == ST_FETCH) || (r_state == ST_DRAIN));
  assign w_accept = w_req && imem_ready;
  assign w_pc_inc = r_pc + PC_STEP;

  assign imem_req  = w_req;
  // DRAIN replays the abandoned address so the memory sees a stable request.
  assign imem_addr = (r_state == ST_DRAIN) ? r_drain_addr : r_pc;

  if_id_buf u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .i_wr  (w_buf_wr),
    .i_clr (w_buf_clr),
    .i_pc  (w_pc_inc),
    .i_ir  (imem_rdata),
    .o_vld (w_buf_vld),
    .o_pc  (w_buf_pc),
    .o_ir  (w_buf_ir)
  );

  // Next-state decode; priority is halted > halt > flush > normal per-state behaviour.
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_pc      = r_pc;
    w_nxt_drain   = r_drain_addr;
    w_ifid_ld     = 1'b0;
    w_ifid_bubble = 1'b0;
    w_ifid_pc     = '0;
    w_ifid_ir     = NOP_IR;
    w_cnt_inc     = 1'b0;
    w_buf_wr      = 1'b0;
    w_buf_clr     = 1'b0;

    if (r_state == ST_HALTED) begin
      // Sticky until reset; IF/ID already holds a bubble from the halt cycle.
      w_nxt_state = ST_HALTED;
    end else if (halt) begin
      // Any word accepted this cycle is simply not captured.
      w_nxt_state   = ST_HALTED;
      w_ifid_bubble = 1'b1;
      w_buf_clr     = 1'b1;
    end else if (flush) begin
      w_nxt_pc      = word_align(redirect_pc);
      w_ifid_bubble = 1'b1;
      w_buf_clr     = 1'b1;
      if (w_req && !imem_ready) begin
        // Memory has not taken the old request: keep presenting it and
        // throw away its data when it finally completes.
        w_nxt_state = ST_DRAIN;
        if (r_state == ST_FETCH) begin
          w_nxt_drain = r_pc;
        end
      end else begin
        w_nxt_state = ST_FETCH;
      end
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (w_accept) begin
            w_nxt_pc = w_pc_inc;
            if (stall) begin
              w_buf_wr    = 1'b1;
              w_nxt_state = ST_HOLD;
            end else begin
              w_ifid_ld = 1'b1;
              w_ifid_pc = w_pc_inc;
              w_ifid_ir = imem_rdata;
              w_cnt_inc = 1'b1;
            end
          end else if (!stall) begin
            w_ifid_bubble = 1'b1;
          end
        end
        ST_HOLD: begin
          // Release the parked word directly; no bubble on this transition.
          if (!stall && w_buf_vld) begin
            w_ifid_ld   = 1'b1;
            w_ifid_pc   = w_buf_pc;
            w_ifid_ir   = w_buf_ir;
            w_cnt_inc   = 1'b1;
            w_buf_clr   = 1'b1;
            w_nxt_state = ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (imem_ready) begin
            w_nxt_state = ST_FETCH;
          end
        end
        default: begin
          w_nxt_state = ST_FETCH;
        end
      endcase
    end
  end

  // FSM, fetch pointer and the replay address for DRAIN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_FETCH;
      r_pc         <= RESET_PC;
      r_drain_addr <= RESET_PC;
    end else begin
      r_state      <= w_nxt_state;
      r_pc         <= w_nxt_pc;
      r_drain_addr <= w_nxt_drain;
    end
  end

  // IF/ID pipeline register: bubble, new instruction, or hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_pc  <= '0;
      r_out_ir  <= NOP_IR;
      r_out_sig <= BUBBLE_SIG;
    end else if (w_ifid_bubble) begin
      r_out_pc  <= '0;
      r_out_ir  <= NOP_IR;
      r_out_sig <= BUBBLE_SIG;
    end else if (w_ifid_ld) begin
      r_out_pc  <= w_ifid_pc;
      r_out_ir  <= w_ifid_ir;
      r_out_sig <= '0;
    end
  end

  // Count of real instructions handed to ID; wraps modulo 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_count <= '0;
    end else if (w_cnt_inc) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign out_pc      = r_out_pc;
  assign out_ir      = r_out_ir;
  assign out_signal  = r_out_sig;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized traffic against a queue-based model.
// Memory responds combinationally with rdata = addr ^ rd_xor.
// Inputs driven 2 time units after the rising edge; outputs compared on the falling edge.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] BUB    = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] out_pc;
  logic [31:0] out_ir;
  logic [31:0] out_signal;
  logic [31:0] fetch_count;
  logic [31:0] rd_xor;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ rd_xor;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .out_pc      (out_pc),
    .out_ir      (out_ir),
    .out_signal  (out_signal),
    .fetch_count (fetch_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } ent_t;

  ent_t        held[$];       // words accepted but not yet delivered to ID
  logic [31:0] m_pc;          // next address to fetch
  logic [31:0] m_drain_addr;  // address of an abandoned request still open
  bit          m_draining;
  bit          m_halted;
  bit          m_ok = 1'b0;
  logic [31:0] m_out_pc, m_out_ir, m_out_sig, m_count;

  function automatic bit m_req();
    return rst_n && !m_halted && (held.size() == 0);
  endfunction

  function automatic logic [31:0] m_addr();
    return m_draining ? m_drain_addr : m_pc;
  endfunction

  task automatic m_bubble();
    m_out_pc  = 32'h0;
    m_out_ir  = 32'h0;
    m_out_sig = BUB;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ok         = 1'b1;
      m_pc         = RST_PC;
      m_drain_addr = RST_PC;
      m_draining   = 1'b0;
      m_halted     = 1'b0;
      held.delete();
      m_bubble();
      m_count      = 32'h0;
    end else if (m_ok && !m_halted) begin
      if (halt) begin
        m_halted = 1'b1;
        held.delete();
        m_bubble();
      end else if (flush) begin
        if (m_req() && !imem_ready) begin
          if (!m_draining) m_drain_addr = m_pc;
          m_draining = 1'b1;
        end else begin
          m_draining = 1'b0;
        end
        m_pc = redirect_pc & 32'hFFFF_FFFC;
        held.delete();
        m_bubble();
      end else if (held.size() > 0) begin
        if (!stall) begin
          ent_t e;
          e = held.pop_front();
          m_out_pc  = e.pc;
          m_out_ir  = e.ir;
          m_out_sig = 32'h0;
          m_count   = m_count + 32'd1;
        end
      end else if (m_draining) begin
        if (imem_ready) m_draining = 1'b0;
      end else if (imem_ready) begin
        ent_t e;
        e.pc = m_pc + 32'd4;
        e.ir = m_pc ^ rd_xor;
        m_pc = m_pc + 32'd4;
        if (stall) begin
          held.push_back(e);
        end else begin
          m_out_pc  = e.pc;
          m_out_ir  = e.ir;
          m_out_sig = 32'h0;
          m_count   = m_count + 32'd1;
        end
      end else if (!stall) begin
        m_bubble();
      end
    end
  end

  // Compare DUT against model every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("imem_req", {31'b0, imem_req}, {31'b0, m_req()});
      if (m_req()) chk("imem_addr", imem_addr, m_addr());
      chk("out_pc", out_pc, m_out_pc);
      chk("out_ir", out_ir, m_out_ir);
      chk("out_signal", out_signal, m_out_sig);
      chk("fetch_count", fetch_count, m_count);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ready_pct;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; halt = 1'b0;
    imem_ready = 1'b0; redirect_pc = 32'h0; rd_xor = 32'h0;
    cyc(); cyc();
    chk("rst_sig", out_signal, BUB);
    chk("rst_ir", out_ir, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_cnt", fetch_count, 32'h0);
    chk("rst_req_low", {31'b0, imem_req}, 32'h0);

    // Back-to-back fetch with rdata == addr
    rst_n = 1'b1; imem_ready = 1'b1;
    #1;
    chk("first_req", {31'b0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, RST_PC);
    cyc();
    chk("seq_ir0", out_ir, 32'h0);
    chk("seq_pc0", out_pc, 32'h4);
    chk("seq_sig0", out_signal, 32'h0);
    cyc();
    chk("seq_ir1", out_ir, 32'h4);
    cyc();
    chk("seq_ir2", out_ir, 32'h8);
    chk("seq_pc2", out_pc, 32'hC);
    chk("seq_cnt", fetch_count, 32'd3);

    // Accept under stall, hold three cycles, release
    stall = 1'b1;
    cyc();
    chk("hold_req", {31'b0, imem_req}, 32'h0);
    chk("hold_ir", out_ir, 32'h8);
    cyc(); cyc();
    chk("hold_ir3", out_ir, 32'h8);
    chk("hold_cnt", fetch_count, 32'd3);
    stall = 1'b0;
    cyc();
    chk("rel_ir", out_ir, 32'hC);
    chk("rel_pc", out_pc, 32'h10);
    chk("rel_cnt", fetch_count, 32'd4);
    cyc();
    chk("after_rel_ir", out_ir, 32'h10);
    chk("after_rel_cnt", fetch_count, 32'd5);

    // Not ready, then flush: old address held, then redirect
    imem_ready = 1'b0;
    cyc();
    chk("wait_sig", out_signal, BUB);
    chk("wait_addr", imem_addr, 32'h14);
    flush = 1'b1; redirect_pc = 32'h0000_0101;
    cyc();
    flush = 1'b0;
    chk("drain_addr", imem_addr, 32'h14);
    chk("drain_req", {31'b0, imem_req}, 32'h1);
    cyc();
    chk("drain_addr2", imem_addr, 32'h14);
    chk("drain_sig", out_signal, BUB);
    imem_ready = 1'b1;
    cyc();
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_sig", out_signal, BUB);
    chk("redir_cnt", fetch_count, 32'd5);
    cyc();
    chk("redir_ir", out_ir, 32'h100);
    chk("redir_pc", out_pc, 32'h104);

    // Flush together with stall
    stall = 1'b1; flush = 1'b1; redirect_pc = 32'h200;
    cyc();
    stall = 1'b0; flush = 1'b0;
    chk("fs_sig", out_signal, BUB);
    chk("fs_addr", imem_addr, 32'h200);
    chk("fs_cnt", fetch_count, 32'd6);

    // PC wrap
    flush = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    flush = 1'b0;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    cyc();
    chk("wrap_ir", out_ir, 32'hFFFF_FFFC);
    chk("wrap_pc", out_pc, 32'h0);
    chk("wrap_addr1", imem_addr, 32'h0);

    // Randomized traffic
    ready_pct = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) ready_pct = $urandom_range(20, 100);
      rst_n       = ($urandom_range(0, 199) != 0);
      halt        = ($urandom_range(0, 149) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      stall       = ($urandom_range(0, 2) == 0);
      imem_ready  = ($urandom_range(0, 99) < ready_pct);
      redirect_pc = $urandom;
      rd_xor      = $urandom;
      cyc();
    end

    // Halt, then reset recovery
    rst_n = 1'b0; halt = 1'b0; flush = 1'b0; stall = 1'b0;
    imem_ready = 1'b1; rd_xor = 32'h0;
    cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    halt = 1'b1; flush = 1'b1; redirect_pc = 32'h400;
    cyc();
    halt = 1'b0;
    chk("halt_req", {31'b0, imem_req}, 32'h0);
    chk("halt_sig", out_signal, BUB);
    cyc(); flush = 1'b0; cyc();
    chk("halted_req", {31'b0, imem_req}, 32'h0);
    chk("halted_cnt", fetch_count, 32'd2);
    rst_n = 1'b0;
    cyc();
    chk("halt_rst_req", {31'b0, imem_req}, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("halt_exit_req", {31'b0, imem_req}, 32'h1);
    chk("halt_exit_addr", imem_addr, RST_PC);
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
